// File: rtl/stream_fifo_pipe_flow.sv
// ---------------------------------------------------------------------------
// stream_fifo_pipe_flow
//   Valid/ready stream FIFO with pipe-through at full. A read-side accept
//   frees a slot in the same cycle, so the write side stays ready even when
//   every entry is occupied. Supports arbitrary (non-power-of-two) depth, an
//   occupancy count, an almost-full flag and a synchronous flush.
//
//   Optional feature: define STREAM_FIFO_FLOW_EN to enable fall-through when
//   empty (write payload visible on the read side in the same cycle).
//
// Parameters
//   DATA_WIDTH    payload width in bits
//   FIFO_DEPTH    number of entries (any integer >= 1)
//   AFULL_THRESH  afull_o asserted when count_o >= AFULL_THRESH
//
// Ports
//   clk        clock, all state updates on rising edge
//   rst        synchronous reset, active-high
//   flush_i    synchronous discard of all entries
//   w_valid_i  write-side valid
//   w_ready_o  write-side ready
//   w_data_i   write payload
//   r_valid_o  read-side valid
//   r_ready_i  read-side ready
//   r_data_o   read payload (head entry)
//   count_o    entries currently stored
//   afull_o    count_o >= AFULL_THRESH
// ---------------------------------------------------------------------------
module stream_fifo_pipe_flow #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            w_valid_i,
  output logic                            w_ready_o,
  input  logic [DATA_WIDTH-1:0]           w_data_i,
  output logic                            r_valid_o,
  input  logic                            r_ready_i,
  output logic [DATA_WIDTH-1:0]           r_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            afull_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // Write side is ready when not full, or when full but the head is being
  // accepted this cycle (the vacated slot is the one being written).
  assign w_ready_o = !flush_i && (!w_full || r_ready_i);

`ifdef STREAM_FIFO_FLOW_EN
  // Empty FIFO presents the write payload directly; if it is accepted in the
  // same cycle the word never touches storage.
  assign r_valid_o = !flush_i && (!w_empty || w_valid_i);
  assign r_data_o  = w_empty ? w_data_i : r_mem[r_rd_ptr];
  assign w_bypass  = !flush_i && w_empty && w_valid_i && r_ready_i;
`else
  assign r_valid_o = !flush_i && !w_empty;
  assign r_data_o  = r_mem[r_rd_ptr];
  assign w_bypass  = 1'b0;
`endif

  assign w_push = w_valid_i && w_ready_o && !w_bypass;
  // Pops come from storage only; a bypassed word is not a storage pop.
  assign w_pop  = !flush_i && !w_empty && r_ready_i;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_data_i;
  end

  assign count_o = r_count;
  assign afull_o = (r_count >= CNT_AF);

endmodule

// File: tb/tb_stream_fifo_pipe_flow.sv
// ---------------------------------------------------------------------------
// tb_stream_fifo_pipe_flow
//   Directed self-checking bench for stream_fifo_pipe_flow with
//   DATA_WIDTH=8, FIFO_DEPTH=3, AFULL_THRESH=2. Inputs change 1ns after the
//   rising edge; outputs are checked 2ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_stream_fifo_pipe_flow;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  logic       w_valid_i;
  logic       w_ready_o;
  logic [7:0] w_data_i;
  logic       r_valid_o;
  logic       r_ready_i;
  logic [7:0] r_data_o;
  logic [1:0] count_o;
  logic       afull_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  stream_fifo_pipe_flow #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (3),
    .AFULL_THRESH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .w_valid_i(w_valid_i),
    .w_ready_o(w_ready_o),
    .w_data_i (w_data_i),
    .r_valid_o(r_valid_o),
    .r_ready_i(r_ready_i),
    .r_data_o (r_data_o),
    .count_o  (count_o),
    .afull_o  (afull_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs may be changed right after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; w_valid_i = 1'b1; w_data_i = 8'hAA; r_ready_i = 1'b0;
    tick();
    tick();
    #1;
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_tests++; if (w_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %b exp 1", w_ready_o); end
    rst = 1'b0; w_valid_i = 1'b0;
    #1;
    n_tests++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", r_valid_o); end
    n_tests++; if (afull_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", afull_o); end
    tick();
    #1;
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_nopush got %0d exp 0", count_o); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    r_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_valid_i = 1'b1; w_data_i = vals[i];
      tick();
      w_valid_i = 1'b0;
      #1;
      n_tests++; if (count_o !== 2'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count_o, i + 1); end
      n_tests++; if (afull_o !== (i >= 1)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, afull_o, (i >= 1)); end
    end
    w_valid_i = 1'b1; w_data_i = 8'hEE;
    #1;
    n_tests++; if (w_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_wready got %b exp 0", w_ready_o); end
    w_valid_i = 1'b0;
    r_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (r_valid_o !== 1'b1 || r_data_o !== vals[i]) begin n_fail++; $display("FAIL drain_data[%0d] got v=%b d=%h exp v=1 d=%h", i, r_valid_o, r_data_o, vals[i]); end
      tick();
    end
    r_ready_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd0 || r_valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty got c=%0d v=%b exp c=0 v=0", count_o, r_valid_o); end
  endtask

  task automatic test_pipe_through();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    r_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_valid_i = 1'b1; w_data_i = vals[i];
      tick();
    end
    w_data_i = 8'h44; r_ready_i = 1'b1;
    #1;
    n_tests++; if (w_ready_o !== 1'b1) begin n_fail++; $display("FAIL pipe_wready got %b exp 1", w_ready_o); end
    n_tests++; if (r_data_o !== 8'h11) begin n_fail++; $display("FAIL pipe_head got %h exp 11", r_data_o); end
    tick();
    w_valid_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd3) begin n_fail++; $display("FAIL pipe_count got %0d exp 3", count_o); end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (r_valid_o !== 1'b1 || r_data_o !== vals[i]) begin n_fail++; $display("FAIL pipe_read[%0d] got v=%b d=%h exp v=1 d=%h", i, r_valid_o, r_data_o, vals[i]); end
      tick();
      #1;
    end
    r_ready_i = 1'b0;
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL pipe_empty got %0d exp 0", count_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_head;
    r_ready_i = 1'b0; w_valid_i = 1'b1; w_data_i = 8'hF0;
    tick();
    exp_head = 8'hF0;
    r_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      w_data_i = 8'(i);
      #1;
      n_tests++; if (r_data_o !== exp_head) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", i, r_data_o, exp_head); end
      tick();
      #1;
      n_tests++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp 1", i, count_o); end
      exp_head = 8'(i);
    end
    w_valid_i = 1'b0;
    #1;
    n_tests++; if (r_data_o !== 8'h0A) begin n_fail++; $display("FAIL wrap_last got %h exp 0a", r_data_o); end
    tick();
    r_ready_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL wrap_empty got %0d exp 0", count_o); end
  endtask

  task automatic test_flush();
    r_ready_i = 1'b0; w_valid_i = 1'b1; w_data_i = 8'h77;
    tick();
    w_data_i = 8'h88;
    tick();
    w_valid_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd2 || afull_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre got c=%0d af=%b exp c=2 af=1", count_o, afull_o); end
    flush_i = 1'b1; w_valid_i = 1'b1; w_data_i = 8'h99; r_ready_i = 1'b1;
    #1;
    n_tests++; if (w_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_wready got %b exp 0", w_ready_o); end
    n_tests++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_rvalid got %b exp 0", r_valid_o); end
    tick();
    flush_i = 1'b0; w_valid_i = 1'b0; r_ready_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd0 || afull_o !== 1'b0 || r_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_post got c=%0d af=%b v=%b exp c=0 af=0 v=0", count_o, afull_o, r_valid_o); end
    w_valid_i = 1'b1; w_data_i = 8'h55;
    tick();
    w_valid_i = 1'b0;
    #1;
    n_tests++; if (r_valid_o !== 1'b1 || r_data_o !== 8'h55 || count_o !== 2'd1) begin n_fail++; $display("FAIL flush_refill got v=%b d=%h c=%0d exp v=1 d=55 c=1", r_valid_o, r_data_o, count_o); end
    r_ready_i = 1'b1;
    tick();
    r_ready_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL flush_drain got %0d exp 0", count_o); end
  endtask

  task automatic test_flow();
    w_valid_i = 1'b1; w_data_i = 8'h66; r_ready_i = 1'b1;
    #1;
`ifdef STREAM_FIFO_FLOW_EN
    n_tests++; if (r_valid_o !== 1'b1 || r_data_o !== 8'h66) begin n_fail++; $display("FAIL flow_same got v=%b d=%h exp v=1 d=66", r_valid_o, r_data_o); end
    tick();
    w_valid_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd0 || r_valid_o !== 1'b0) begin n_fail++; $display("FAIL flow_count got c=%0d v=%b exp c=0 v=0", count_o, r_valid_o); end
`else
    n_tests++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL flow_same got v=%b exp v=0", r_valid_o); end
    tick();
    w_valid_i = 1'b0;
    #1;
    n_tests++; if (count_o !== 2'd1 || r_valid_o !== 1'b1 || r_data_o !== 8'h66) begin n_fail++; $display("FAIL flow_next got c=%0d v=%b d=%h exp c=1 v=1 d=66", count_o, r_valid_o, r_data_o); end
    tick();
    #1;
    n_tests++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL flow_drain got %0d exp 0", count_o); end
`endif
    r_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_pipe_through();
    test_wrap();
    test_flush();
    test_flow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
